uart_tx_mmio: RTL and testbench

Memory-mapped UART transmitter on the rv core's shared `addr`/`bus` pair, sitting beside `mem` as a downstream consumer of stores. A byte store to the DATA register queues the byte in a small FIFO, and a serializer shifts it out on `txd` as 8N1, LSB first. A STATUS register lets software poll FIFO state and overflow. It is the CPU's first output path for debug prints.

---
 rtl/uart_pkg.sv | 28 ++
 rtl/sync_fifo.sv | 62 ++++++
 rtl/uart_tx_mmio.sv | 188 ++++++++++++++++++
 tb/tb_uart_tx_mmio.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
//------------------------------------------------------------------------------
// Module   : uart_pkg
// Brief    : Shared types and constants for the memory-mapped UART transmitter.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package uart_pkg;

    typedef enum logic [2:0] {
        UART_IDLE   = 3'd0,
        UART_START  = 3'd1,
        UART_DATA   = 3'd2,
        UART_PARITY = 3'd3,
        UART_STOP   = 3'd4
    } uart_state_e;

    localparam logic [31:0] UART_DATA_OFS = 32'd0;
    localparam logic [31:0] UART_STAT_OFS = 32'd4;

    localparam int UART_STAT_FULL  = 0;
    localparam int UART_STAT_EMPTY = 1;
    localparam int UART_STAT_BUSY  = 2;
    localparam int UART_STAT_OVF   = 3;

endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
//------------------------------------------------------------------------------
// Module   : sync_fifo
// Brief    : Single-clock FIFO with extra-MSB pointers; push into a full FIFO is
//            accepted only when a pop happens in the same cycle.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: pointers alone define valid contents.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
    end

endmodule

`default_nettype wire

// File: rtl/uart_tx_mmio.sv
//------------------------------------------------------------------------------
// Module   : uart_tx_mmio
// Brief    : Memory-mapped 8N1 UART transmitter (DATA/STATUS registers, FIFO,
//            serializer). Optional even parity with UART_TX_PARITY_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module uart_tx_mmio
    import uart_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = 32'h0000_2000,
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    inout  wire  [31:0] bus,
    input  logic        write,
    input  logic        read,
    output logic        txd,
    output logic        busy
);

    localparam int             BW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0]  BAUD_MAX = BW'(CLKS_PER_BIT - 1);

    if (CLKS_PER_BIT < 2) begin : g_bad_cpb
        $error("CLKS_PER_BIT must be at least 2");
    end
    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of two, at least 2");
    end

    logic        hit_data, hit_stat;
    logic        fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [7:0]  fifo_dout;
    logic [31:0] stat_word, rd_data;
    logic        fsm_busy, baud_last;

    uart_state_e state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic        txd_q, txd_d;
    logic        ovf_q, ovf_d;
`ifdef UART_TX_PARITY_EN
    logic        parity_q, parity_d;
`endif

    assign hit_data  = (addr == BASE_ADDR + UART_DATA_OFS);
    assign hit_stat  = (addr == BASE_ADDR + UART_STAT_OFS);
    assign fifo_push = write && hit_data;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (bus[7:0]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign fsm_busy  = (state_q != UART_IDLE);
    assign busy      = fsm_busy || !fifo_empty;
    assign txd       = txd_q;
    assign baud_last = (baud_q == BAUD_MAX);

    always_comb begin
        stat_word                  = '0;
        stat_word[UART_STAT_FULL]  = fifo_full;
        stat_word[UART_STAT_EMPTY] = fifo_empty;
        stat_word[UART_STAT_BUSY]  = fsm_busy;
        stat_word[UART_STAT_OVF]   = ovf_q;
        rd_data = hit_stat ? stat_word : 32'h0;
    end

    assign bus = (read && (hit_stat || hit_data)) ? rd_data : 'z;

    always_comb begin
        ovf_d = ovf_q;
        if (write && hit_stat && bus[UART_STAT_OVF]) ovf_d = 1'b0;
        if (fifo_push && fifo_full && !fifo_pop)     ovf_d = 1'b1;
    end

    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        fifo_pop  = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d  = parity_q;
`endif
        if (state_q != UART_IDLE) baud_d = baud_last ? '0 : baud_q + 1'b1;

        case (state_q)
            UART_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    shift_d   = fifo_dout;
                    baud_d    = '0;
                    bit_cnt_d = '0;
                    state_d   = UART_START;
`ifdef UART_TX_PARITY_EN
                    parity_d  = ^fifo_dout;
`endif
                end
            end
            UART_START: if (baud_last) state_d = UART_DATA;
            UART_DATA: begin
                if (baud_last) begin
                    shift_d   = {1'b0, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = UART_PARITY;
`else
                        state_d = UART_STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            UART_PARITY: if (baud_last) state_d = UART_STOP;
`endif
            UART_STOP: begin
                if (baud_last) begin
                    // Chain straight into the next frame so frames stay contiguous.
                    if (!fifo_empty) begin
                        fifo_pop  = 1'b1;
                        shift_d   = fifo_dout;
                        bit_cnt_d = '0;
                        state_d   = UART_START;
`ifdef UART_TX_PARITY_EN
                        parity_d  = ^fifo_dout;
`endif
                    end else begin
                        state_d   = UART_IDLE;
                    end
                end
            end
            default: state_d = UART_IDLE;
        endcase

        case (state_d)
            UART_START:  txd_d = 1'b0;
            UART_DATA:   txd_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            UART_PARITY: txd_d = parity_d;
`endif
            default:     txd_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= UART_IDLE;
            baud_q    <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            txd_q     <= 1'b1;
            ovf_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            txd_q     <= txd_d;
            ovf_q     <= ovf_d;
`ifdef UART_TX_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_mmio.sv
//------------------------------------------------------------------------------
// Module   : tb_uart_tx_mmio
// Brief    : Self-checking bench for uart_tx_mmio (CLKS_PER_BIT=4, FIFO_DEPTH=4).
//            Honours UART_TX_PARITY_EN for the frame shape.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_uart_tx_mmio;

    localparam logic [31:0] BASE = 32'h0000_2000;
    localparam int          CPB  = 4;
`ifdef UART_TX_PARITY_EN
    localparam int          FRAME_BITS = 11;
`else
    localparam int          FRAME_BITS = 10;
`endif
    localparam int          FRAME_CYC  = FRAME_BITS * CPB;
    localparam logic [31:0] ZREAD      = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] addr = '0;
    logic        write = 1'b0;
    logic        read = 1'b0;
    logic        bus_oe = 1'b0;
    logic [31:0] bus_drv = '0;
    wire  [31:0] bus;
    logic        txd;
    logic        busy;

    int n_chk  = 0;
    int n_fail = 0;
    logic [7:0] sbytes [0:7];

    assign bus = bus_oe ? bus_drv : 'z;
    pullup (bus);

    always #5 clk = ~clk;

    uart_tx_mmio #(
        .BASE_ADDR    (BASE),
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (4)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .addr  (addr),
        .bus   (bus),
        .write (write),
        .read  (read),
        .txd   (txd),
        .busy  (busy)
    );

    typedef struct {
        logic        wr;
        logic        rd;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] exp_bus;
        logic        exp_busy;
    } vec_t;

    vec_t vecs [0:11];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic exp_bit(input logic [7:0] b, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return b[idx-1];
`ifdef UART_TX_PARITY_EN
        if (idx == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    task automatic do_stores(input int n);
        @(posedge clk);
        #1;
        for (int i = 0; i < n; i++) begin
            write   = 1'b1;
            addr    = BASE;
            bus_oe  = 1'b1;
            bus_drv = {24'h5A5A5A, sbytes[i]};
            @(posedge clk);
            #1;
        end
        write  = 1'b0;
        bus_oe = 1'b0;
    endtask

    // Starts sampling at the negedge after the first store edge.
    task automatic check_frames(input int nframe, input int max_cycles);
        int total;
        total = nframe * FRAME_CYC;
        if (max_cycles < total) total = max_cycles;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("txd_before_start", {31'b0, txd}, 32'h1);
        chk("busy_after_store", {31'b0, busy}, 32'h1);
        for (int k = 0; k < total; k++) begin
            @(negedge clk);
            chk($sformatf("txd_f%0d_c%0d", k / FRAME_CYC, k % FRAME_CYC), {31'b0, txd},
                {31'b0, exp_bit(sbytes[k / FRAME_CYC], (k % FRAME_CYC) / CPB)});
        end
    endtask

    task automatic read_status(input string nm, input logic [31:0] exp);
        @(posedge clk);
        #1;
        addr = BASE + 32'd4;
        read = 1'b1;
        @(negedge clk);
        chk(nm, bus, exp);
        #1;
        read = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //            wr    rd    addr            wdata          exp bus        busy
        vecs[0]  = '{1'b0, 1'b1, BASE + 32'd4,  32'h0,         32'h0000_0002, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, BASE,          32'h0,         32'h0000_0000, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, BASE + 32'd4,  32'h0,         ZREAD,         1'b0};
        vecs[3]  = '{1'b0, 1'b1, BASE + 32'd8,  32'h0,         ZREAD,         1'b0};
        vecs[4]  = '{1'b0, 1'b1, BASE + 32'd12, 32'h0,         ZREAD,         1'b0};
        vecs[5]  = '{1'b1, 1'b0, BASE + 32'd8,  32'h0000_0055, ZREAD,         1'b0};
        vecs[6]  = '{1'b1, 1'b0, BASE + 32'd12, 32'h0000_0041, ZREAD,         1'b0};
        vecs[7]  = '{1'b0, 1'b1, BASE + 32'd4,  32'h0,         32'h0000_0002, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, BASE + 32'd4,  32'h0000_0008, ZREAD,         1'b0};
        vecs[9]  = '{1'b0, 1'b1, BASE + 32'd4,  32'h0,         32'h0000_0002, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 32'h0000_0000, 32'h0,         ZREAD,         1'b0};
        vecs[11] = '{1'b0, 1'b1, BASE + 32'd5,  32'h0,         ZREAD,         1'b0};

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset_txd", {31'b0, txd}, 32'h1);
        chk("reset_busy", {31'b0, busy}, 32'h0);

        // Register decode vectors, one access per cycle.
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            write   = vecs[i].wr;
            read    = vecs[i].rd;
            addr    = vecs[i].a;
            bus_oe  = vecs[i].wr;
            bus_drv = vecs[i].wd;
            @(negedge clk);
            if (!vecs[i].wr) chk($sformatf("vec%0d_bus", i), bus, vecs[i].exp_bus);
            chk($sformatf("vec%0d_busy", i), {31'b0, busy}, {31'b0, vecs[i].exp_busy});
            chk($sformatf("vec%0d_txd", i), {31'b0, txd}, 32'h1);
        end
        @(posedge clk);
        #1;
        write  = 1'b0;
        read   = 1'b0;
        bus_oe = 1'b0;

        // Single frame 0x55.
        sbytes[0] = 8'h55;
        fork
            do_stores(1);
            check_frames(1, 1000);
        join
        @(negedge clk);
        chk("idle_after_55_busy", {31'b0, busy}, 32'h0);
        chk("idle_after_55_txd", {31'b0, txd}, 32'h1);

        // Six back-to-back stores: five accepted, the sixth overflows.
        for (int i = 0; i < 6; i++) sbytes[i] = 8'h41 + 8'(i);
        fork
            begin
                do_stores(6);
                addr = BASE + 32'd4;
                read = 1'b1;
                @(negedge clk);
                chk("status_ovf", bus, 32'h0000_000D);
                @(posedge clk);
                #1;
                read    = 1'b0;
                write   = 1'b1;
                bus_oe  = 1'b1;
                bus_drv = 32'h0000_0008;
                @(posedge clk);
                #1;
                write  = 1'b0;
                bus_oe = 1'b0;
                read   = 1'b1;
                @(negedge clk);
                chk("status_ovf_cleared", bus, 32'h0000_0005);
                #1;
                read = 1'b0;
            end
            check_frames(5, 1000);
        join
        @(negedge clk);
        chk("idle_after_burst_busy", {31'b0, busy}, 32'h0);
        read_status("status_after_burst", 32'h0000_0002);

        // Reset during data bit 3 with two bytes still queued.
        sbytes[0] = 8'hA5;
        sbytes[1] = 8'h3C;
        sbytes[2] = 8'h96;
        fork
            do_stores(3);
            check_frames(1, 18);
        join
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midframe_rst_txd", {31'b0, txd}, 32'h1);
        chk("midframe_rst_busy", {31'b0, busy}, 32'h0);
        for (int k = 0; k < 45; k++) begin
            @(negedge clk);
            chk($sformatf("post_rst_txd_c%0d", k), {31'b0, txd}, 32'h1);
        end
        read_status("status_after_rst", 32'h0000_0002);

        // 0x07 exercises the parity bit when enabled.
        sbytes[0] = 8'h07;
        fork
            do_stores(1);
            check_frames(1, 1000);
        join
        @(negedge clk);
        chk("idle_after_07_busy", {31'b0, busy}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
